// File: rtl/mio_bus_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O bus controller:
// FSM encodings, slot IDs and default slot configuration.
package mio_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } mio_state_e;

  localparam logic [3:0] SLOT_RAM   = 4'd0;
  localparam logic [3:0] SLOT_VRAM  = 4'd1;
  localparam logic [3:0] SLOT_PS2   = 4'd2;
  localparam logic [3:0] SLOT_SRC   = 4'd3;
  localparam logic [3:0] SLOT_MAP   = 4'd4;
  localparam logic [3:0] SLOT_WIN   = 4'd5;
  localparam logic [3:0] SLOT_LOSE  = 4'd6;
  localparam logic [3:0] SLOT_GPIOE = 4'd14;
  localparam logic [3:0] SLOT_GPIOF = 4'd15;

  localparam int MIO_NSLV = 8;
  localparam int MIO_WW   = 3;
  localparam logic [MIO_NSLV*MIO_WW-1:0] MIO_WAIT_DEFAULT = '0;
  localparam logic [7:0] MIO_MASK_DEFAULT = 8'h7F;

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side and slave-side signals of the I/O bus controller.
// master = CPU/slave environment, slave = the controller itself.
interface mio_bus_ctrl_if #(
  parameter int NSLV = 8,
  parameter int DW   = 32,
  parameter int AW   = 19
);
  logic                 mem_req;
  logic                 mem_w;
  logic [31:0]          addr_bus;
  logic [DW-1:0]        Cpu_data2bus;
  logic                 vga_rdn;
  logic [NSLV*DW-1:0]   slv_rdata;
  logic                 MIO_ready;
  logic [DW-1:0]        Cpu_data4bus;
  logic [NSLV-1:0]      slv_sel;
  logic                 slv_we;
  logic [AW-1:0]        slv_addr;
  logic [DW-1:0]        slv_wdata;
  logic                 bus_err;

  modport master (
    output mem_req, mem_w, addr_bus, Cpu_data2bus, vga_rdn, slv_rdata,
    input  MIO_ready, Cpu_data4bus, slv_sel, slv_we, slv_addr, slv_wdata, bus_err
  );

  modport slave (
    input  mem_req, mem_w, addr_bus, Cpu_data2bus, vga_rdn, slv_rdata,
    output MIO_ready, Cpu_data4bus, slv_sel, slv_we, slv_addr, slv_wdata, bus_err
  );
endinterface

// File: rtl/mio_bus_ctrl_slot_dec.sv
// Combinational slot decode: one-hot select, mapped flag and wait-state lookup.
// Slot indices at or above NSLV decode as unmapped with no select.
module mio_slot_dec
  import mio_bus_ctrl_pkg::*;
#(
  parameter int                   NSLV     = MIO_NSLV,
  parameter int                   WW       = MIO_WW,
  parameter logic [NSLV*WW-1:0]   WAIT_CFG = '0,
  parameter logic [NSLV-1:0]      SLV_MASK = NSLV'(MIO_MASK_DEFAULT)
) (
  input  logic [3:0]      i_slot,
  output logic [NSLV-1:0] o_onehot,
  output logic            o_mapped,
  output logic [WW-1:0]   o_wait
);

  always_comb begin
    o_onehot = '0;
    o_mapped = 1'b0;
    o_wait   = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (i_slot == 4'(i)) begin
        o_onehot[i] = 1'b1;
        o_mapped    = SLV_MASK[i];
        o_wait      = WAIT_CFG[i*WW +: WW];
      end
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Sequential MMIO controller: latches a CPU access, decodes the slot, applies
// per-slot wait states, arbitrates VRAM against VGA and returns registered data.
//
//   state  | meaning
//   IDLE   | waiting for mem_req; latches address/data/direction
//   ARB    | VRAM slot owned by VGA scan-out; nothing selected
//   ACCESS | slave selected; wait counter running down to zero
//   DONE   | one-cycle MIO_ready pulse with captured read data
//   ERR    | one-cycle MIO_ready + bus_err for an unmapped slot
module mio_bus_ctrl
  import mio_bus_ctrl_pkg::*;
#(
  parameter int                 NSLV      = 8,
  parameter int                 DW        = 32,
  parameter int                 AW        = 19,
  parameter int                 WW        = 3,
  parameter logic [NSLV*WW-1:0] WAIT_CFG  = '0,
  parameter logic [NSLV-1:0]    SLV_MASK  = NSLV'(MIO_MASK_DEFAULT),
  parameter logic [3:0]         VRAM_SLOT = SLOT_VRAM
) (
  input  logic          clk,
  input  logic          rst,
  mio_bus_ctrl_if.slave bus
);

  mio_state_e      r_state, w_state_nx;
  logic [3:0]      r_slot;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_is_wr;
  logic            r_wr_pend;
  logic [WW-1:0]   r_wcnt;
  logic [DW-1:0]   r_rdata;

  logic [3:0]      w_slot_idx;
  logic [NSLV-1:0] w_onehot;
  logic            w_mapped;
  logic [WW-1:0]   w_wait;
  logic            w_vram_busy;
  logic [DW-1:0]   w_rdata_sel;
  logic            w_accept, w_load, w_dec, w_capture, w_clr_rdata;
  logic [NSLV-1:0] w_sel;
  logic            w_we, w_ready, w_err;

  // In IDLE decode the incoming address; afterwards the latched slot.
  assign w_slot_idx  = (r_state == S_IDLE) ? bus.addr_bus[31:28] : r_slot;
  assign w_vram_busy = (w_slot_idx == VRAM_SLOT) && !bus.vga_rdn;

  mio_slot_dec #(
    .NSLV     (NSLV),
    .WW       (WW),
    .WAIT_CFG (WAIT_CFG),
    .SLV_MASK (SLV_MASK)
  ) u_slot_dec (
    .i_slot   (w_slot_idx),
    .o_onehot (w_onehot),
    .o_mapped (w_mapped),
    .o_wait   (w_wait)
  );

  always_comb begin
    w_rdata_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_slot == 4'(i)) w_rdata_sel = bus.slv_rdata[i*DW +: DW];
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_capture   = 1'b0;
    w_clr_rdata = 1'b0;
    w_sel       = '0;
    w_we        = 1'b0;
    w_ready     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_req) begin
          w_accept = 1'b1;
          if (!w_mapped) begin
            w_state_nx  = S_ERR;
            w_clr_rdata = 1'b1;
          end else if (w_vram_busy) begin
            w_state_nx = S_ARB;
          end else begin
            w_state_nx = S_ACCESS;
            w_load     = 1'b1;
          end
        end
      end
      S_ARB: begin
        if (bus.vga_rdn) begin
          w_state_nx = S_ACCESS;
          w_load     = 1'b1;
        end
      end
      S_ACCESS: begin
        // VGA preemption gates select and strobe in the same cycle.
        if (w_vram_busy) begin
          w_state_nx = S_ARB;
        end else begin
          w_sel = w_onehot;
          w_we  = r_wr_pend;
          if (r_wcnt == '0) begin
            w_state_nx = S_DONE;
            w_capture  = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_ready    = 1'b1;
        w_state_nx = S_IDLE;
      end
      S_ERR: begin
        w_ready    = 1'b1;
        w_err      = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_is_wr   <= 1'b0;
      r_wr_pend <= 1'b0;
      r_wcnt    <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_slot    <= bus.addr_bus[31:28];
        r_addr    <= bus.addr_bus[AW+1:2];
        r_wdata   <= bus.Cpu_data2bus;
        r_is_wr   <= bus.mem_w;
        r_wr_pend <= bus.mem_w;
      end else if (w_we) begin
        // Pending only until a strobe actually reaches the slave.
        r_wr_pend <= 1'b0;
      end
      if (w_load) begin
        r_wcnt <= w_wait;
      end else if (w_dec) begin
        r_wcnt <= r_wcnt - WW'(1);
      end
      if (w_capture) begin
        r_rdata <= r_is_wr ? '0 : w_rdata_sel;
      end else if (w_clr_rdata) begin
        r_rdata <= '0;
      end
    end
  end

  assign bus.MIO_ready    = w_ready;
  assign bus.bus_err      = w_err;
  assign bus.Cpu_data4bus = r_rdata;
  assign bus.slv_sel      = w_sel;
  assign bus.slv_we       = w_we;
  assign bus.slv_addr     = r_addr;
  assign bus.slv_wdata    = r_wdata;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Scoreboard bench for mio_bus_ctrl: directed accesses push expected completions,
// a negedge monitor pops and compares on every MIO_ready pulse.
module tb_mio_bus_ctrl;

  localparam int NSLV = 8;
  localparam int DW   = 32;
  localparam int AW   = 19;
  localparam int WW   = 3;
  // slot0 W=0, slot1 (VRAM) W=2, slot2 W=1, slot3 W=3, others 0
  localparam logic [NSLV*WW-1:0] TB_WAIT =
    {3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd2, 3'd0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mio_bus_ctrl_if #(.NSLV(NSLV), .DW(DW), .AW(AW)) bus();

  mio_bus_ctrl #(
    .NSLV      (NSLV),
    .DW        (DW),
    .AW        (AW),
    .WW        (WW),
    .WAIT_CFG  (TB_WAIT),
    .SLV_MASK  (8'h7F),
    .VRAM_SLOT (4'd1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string        name;
    int           exp_cyc;
    logic [31:0]  rdata;
    logic         err;
    logic [7:0]   sel;
    logic [18:0]  waddr;
    int           n_sel;
    int           n_we;
    logic [31:0]  wdata;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request for one edge; push the expected completion when one is due.
  task automatic issue(input string name, input logic w, input logic [31:0] addr,
                       input logic [31:0] wd, input int lat, input logic [31:0] rd,
                       input logic err, input logic [7:0] sel, input logic [18:0] waddr,
                       input int nsel, input int nwe, input bit expect_done);
    exp_t e;
    bus.mem_req      = 1'b1;
    bus.mem_w        = w;
    bus.addr_bus     = addr;
    bus.Cpu_data2bus = wd;
    e.name = name; e.exp_cyc = cyc + lat; e.rdata = rd; e.err = err;
    e.sel = sel; e.waddr = waddr; e.n_sel = nsel; e.n_we = nwe; e.wdata = wd;
    if (expect_done) sb.push_back(e);
    @(posedge clk); #1;
    bus.mem_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  int          n_sel_obs = 0;
  int          n_we_obs  = 0;
  logic [7:0]  sel_obs;
  logic [18:0] addr_obs;
  logic [31:0] wd_obs;
  exp_t        me;

  initial begin
    sel_obs = '0; addr_obs = '0; wd_obs = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_sel_obs = 0;
        n_we_obs  = 0;
      end else begin
        if (bus.slv_sel != '0) begin
          n_sel_obs++;
          sel_obs  = bus.slv_sel;
          addr_obs = bus.slv_addr;
        end
        if (bus.slv_we) begin
          n_we_obs++;
          wd_obs = bus.slv_wdata;
        end
        if (bus.MIO_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got MIO_ready=1 expected 0 (cycle %0d)", cyc);
          end else begin
            me = sb.pop_front();
            chk({me.name, "_latency"}, 32'(cyc), 32'(me.exp_cyc));
            chk({me.name, "_rdata"},   bus.Cpu_data4bus, me.rdata);
            chk({me.name, "_bus_err"}, 32'(bus.bus_err), 32'(me.err));
            chk({me.name, "_sel_cycles"}, 32'(n_sel_obs), 32'(me.n_sel));
            chk({me.name, "_we_cycles"},  32'(n_we_obs),  32'(me.n_we));
            if (me.n_sel > 0) begin
              chk({me.name, "_sel"},  32'(sel_obs),  32'(me.sel));
              chk({me.name, "_addr"}, 32'(addr_obs), 32'(me.waddr));
            end
            if (me.n_we > 0) chk({me.name, "_wdata"}, wd_obs, me.wdata);
          end
          n_sel_obs = 0;
          n_we_obs  = 0;
        end else if (bus.bus_err) begin
          chk("bus_err_without_ready", 32'(bus.bus_err), 32'd0);
        end
      end
    end
  end

  initial begin
    bus.mem_req      = 1'b0;
    bus.mem_w        = 1'b0;
    bus.addr_bus     = '0;
    bus.Cpu_data2bus = '0;
    bus.vga_rdn      = 1'b1;
    bus.slv_rdata    = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                        32'h3333_0003, 32'h0BAD_F00D, 32'hCAFE_0001, 32'h1234_5678};

    #1 rst = 1'b1;
    #2;
    chk("reset_ready",  32'(bus.MIO_ready), 32'd0);
    chk("reset_rdata",  bus.Cpu_data4bus, 32'd0);
    chk("reset_sel",    32'(bus.slv_sel), 32'd0);
    chk("reset_we",     32'(bus.slv_we), 32'd0);
    chk("reset_addr",   32'(bus.slv_addr), 32'd0);
    chk("reset_err",    32'(bus.bus_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // name w addr wdata lat rdata err sel waddr nsel nwe
    issue("rd_slot0", 1'b0, 32'h0000_0010, 32'h0, 2, 32'h1234_5678, 1'b0, 8'h01, 19'd4, 1, 0, 1'b1);
    idle(3);
    chk("rdata_hold", bus.Cpu_data4bus, 32'h1234_5678);
    chk("idle_sel",   32'(bus.slv_sel), 32'd0);

    issue("wr_slot3", 1'b1, 32'h3000_0008, 32'hA5A5_A5A5, 5, 32'h0, 1'b0, 8'h08, 19'd2, 4, 1, 1'b1);
    idle(6);

    issue("rd_slot2", 1'b0, 32'h2000_0040, 32'h0, 3, 32'h0BAD_F00D, 1'b0, 8'h04, 19'd16, 2, 0, 1'b1);
    idle(4);

    // VGA owns VRAM for 4 edges: 4 ARB + 3 ACCESS (slot 1 W=2) + DONE
    bus.vga_rdn = 1'b0;
    issue("rd_vga_wait", 1'b0, 32'h1000_0100, 32'h0, 8, 32'hCAFE_0001, 1'b0, 8'h02, 19'd64, 3, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1 bus.vga_rdn = 1'b1;
    idle(6);

    // Preempted in the 2nd ACCESS cycle: restart gives 3 more ACCESS cycles
    issue("rd_preempt", 1'b0, 32'h1000_0200, 32'h0, 7, 32'hCAFE_0001, 1'b0, 8'h02, 19'd128, 4, 0, 1'b1);
    @(posedge clk); #1;
    bus.vga_rdn = 1'b0;
    #1 chk("preempt_gate_sel", 32'(bus.slv_sel), 32'd0);
    @(posedge clk); #1;
    bus.vga_rdn = 1'b1;
    idle(6);

    issue("err_slot7", 1'b0, 32'h7000_0000, 32'h0, 1, 32'h0, 1'b1, 8'h00, 19'd0, 0, 0, 1'b1);
    idle(3);

    // Strobe gated in the first ACCESS cycle is reissued exactly once
    issue("wr_preempt", 1'b1, 32'h1000_0004, 32'h5A5A_0F0F, 6, 32'h0, 1'b0, 8'h02, 19'd1, 3, 1, 1'b1);
    bus.vga_rdn = 1'b0;
    #1 chk("preempt_gate_we", 32'(bus.slv_we), 32'd0);
    @(posedge clk); #1;
    bus.vga_rdn = 1'b1;
    idle(7);

    issue("err_slot15", 1'b0, 32'hF000_0000, 32'h0, 1, 32'h0, 1'b1, 8'h00, 19'd0, 0, 0, 1'b1);
    idle(3);

    issue("rd_slot0_again", 1'b0, 32'h0000_0010, 32'h0, 2, 32'h1234_5678, 1'b0, 8'h01, 19'd4, 1, 0, 1'b1);
    idle(3);

    // Reset during the 2nd ACCESS cycle of a W=3 write: no completion expected
    issue("wr_aborted", 1'b1, 32'h3000_000C, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 8'h08, 19'd3, 0, 0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_rdata", bus.Cpu_data4bus, 32'd0);
    chk("abort_sel",   32'(bus.slv_sel), 32'd0);
    chk("abort_we",    32'(bus.slv_we), 32'd0);
    chk("abort_addr",  32'(bus.slv_addr), 32'd0);
    chk("abort_wdata", bus.slv_wdata, 32'd0);
    chk("abort_ready", 32'(bus.MIO_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(6);
    chk("post_reset_sel", 32'(bus.slv_sel), 32'd0);

    issue("rd_after_rst", 1'b0, 32'h2000_0000, 32'h0, 3, 32'h0BAD_F00D, 1'b0, 8'h04, 19'd0, 2, 0, 1'b1);
    idle(6);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
